mips_multicycle: RTL

- Parametrised multicycle MIPS core; the next generation of the single-cycle mips top.
- Fetch, decode, execute, memory and writeback each take their own state.
- Instruction and data ports are request/ready handshakes, so the core tolerates variable-latency memories.
- Sits between the SoC memory-mapped fabric (imem, dmem, I/O) and the tester, replacing the single-cycle core.

---
 rtl/mips_multicycle.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS core with FETCH/DECODE/EXEC/MEM/WB states and
// request/ready handshakes on the instruction and data ports.
module mips_multicycle #(
   parameter int          Dbits   = 32,
   parameter int          Nreg    = 32,
   parameter logic [31:0] Pc_init = 32'h0040_0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic             imem_req,
   output logic [31:0]      pc,
   input  logic [31:0]      instr,
   input  logic             imem_ready,
   output logic             dmem_req,
   output logic             mem_wr,
   output logic [31:0]      mem_addr,
   output logic [Dbits-1:0] mem_writedata,
   input  logic [Dbits-1:0] mem_readdata,
   input  logic             dmem_ready,
   output logic [2:0]       state,
   output logic             illegal
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
   localparam int RW = $clog2(Nreg);
   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d, pcn_q, pcn_d, ir_q, ir_d, tgt_q, tgt_d;
   logic [Dbits-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
   logic             ill_q, ill_d;
   logic [Dbits-1:0] rf_q [Nreg];
   logic [Dbits-1:0] rf_d [Nreg];
   logic [5:0]       op, fn;
   logic [4:0]       shamt;
   logic [RW-1:0]    rs, rt, rd, wa;
   logic [Dbits-1:0] simm, zimm, y, wd;
   logic             legal, we;
   assign op    = ir_q[31:26];
   assign fn    = ir_q[5:0];
   assign shamt = ir_q[10:6];
   assign rs    = ir_q[21 +: RW];
   assign rt    = ir_q[16 +: RW];
   assign rd    = ir_q[11 +: RW];
   assign simm  = Dbits'($signed(ir_q[15:0]));
   assign zimm  = Dbits'(ir_q[15:0]);
   assign imem_req      = reset && state_q == FETCH;
   assign dmem_req      = state_q == MEM;
   assign mem_wr        = state_q == MEM && op == 6'h2b;
   assign mem_addr      = alu_q[31:0];
   assign mem_writedata = b_q;
   assign pc            = pc_q;
   assign state         = state_q;
   assign illegal       = ill_q;
   always_comb begin
      y     = '0;
      legal = 1'b1;
      case (op)
         6'h00: case (fn)
            6'h20, 6'h21: y = a_q + b_q;
            6'h22, 6'h23: y = a_q - b_q;
            6'h24:        y = a_q & b_q;
            6'h25:        y = a_q | b_q;
            6'h26:        y = a_q ^ b_q;
            6'h27:        y = ~(a_q | b_q);
            6'h2a:        y = Dbits'($signed(a_q) < $signed(b_q));
            6'h2b:        y = Dbits'(a_q < b_q);
            6'h00:        y = b_q << shamt;
            6'h02:        y = b_q >> shamt;
            6'h03:        y = $signed(b_q) >>> shamt;
            6'h08:        y = '0;
            default:      legal = 1'b0;
         endcase
         6'h08, 6'h09, 6'h23, 6'h2b: y = a_q + simm;
         6'h0a:   y = Dbits'($signed(a_q) < $signed(simm));
         6'h0b:   y = Dbits'(a_q < simm);
         6'h0c:   y = a_q & zimm;
         6'h0d:   y = a_q | zimm;
         6'h0e:   y = a_q ^ zimm;
         6'h0f:   y = Dbits'($signed({ir_q[15:0], 16'h0000}));
         6'h02, 6'h03, 6'h04, 6'h05: y = '0;
         default: legal = 1'b0;
      endcase
   end
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pcn_d   = pcn_q;
      ir_d    = ir_q;
      tgt_d   = tgt_q;
      a_d     = a_q;
      b_d     = b_q;
      alu_d   = alu_q;
      mdr_d   = mdr_q;
      ill_d   = ill_q;
      we      = 1'b0;
      wa      = rd;
      wd      = alu_q;
      case (state_q)
         FETCH: if (imem_ready) begin
            ir_d    = instr;
            pcn_d   = pc_q + 32'd4;
            state_d = DECODE;
         end
         DECODE: begin
            a_d     = rf_q[rs];
            b_d     = rf_q[rt];
            tgt_d   = pcn_q + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
            state_d = EXEC;
         end
         EXEC: begin
            alu_d   = y;
            state_d = FETCH;
            if (!legal) begin
               ill_d = 1'b1;
               pc_d  = pcn_q;
            end else if (op == 6'h04 || op == 6'h05)
               pc_d = ((a_q == b_q) ^ (op == 6'h05)) ? tgt_q : pcn_q;
            else if (op == 6'h02 || op == 6'h03) begin
               pc_d = {pcn_q[31:28], ir_q[25:0], 2'b00};
               we   = op == 6'h03;
               wa   = '1;
               wd   = Dbits'(pcn_q);
            end else if (op == 6'h00 && fn == 6'h08)
               pc_d = a_q[31:0];
            else
               state_d = (op == 6'h23 || op == 6'h2b) ? MEM : WB;
         end
         MEM: if (dmem_ready) begin
            mdr_d   = mem_readdata;
            pc_d    = op == 6'h23 ? pc_q : pcn_q;
            state_d = op == 6'h23 ? WB : FETCH;
         end
         WB: begin
            we      = 1'b1;
            wa      = op == 6'h00 ? rd : rt;
            wd      = op == 6'h23 ? mdr_q : alu_q;
            pc_d    = pcn_q;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
      rf_d = rf_q;
      if (we) rf_d[wa] = wd;
      rf_d[0] = '0;
   end
   // enable low freezes every piece of state, so held requests keep stable outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
         pc_q    <= Pc_init;
         pcn_q   <= '0;
         ir_q    <= '0;
         tgt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
         ill_q   <= 1'b0;
         rf_q    <= '{default: '0};
      end else if (enable) begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pcn_q   <= pcn_d;
         ir_q    <= ir_d;
         tgt_q   <= tgt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         alu_q   <= alu_d;
         mdr_q   <= mdr_d;
         ill_q   <= ill_d;
         rf_q    <= rf_d;
      end
   end
endmodule
